// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM encoding,
// frame geometry constants and the parity helper.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Serial bit periods per frame: start + 8 data + stop, optionally + parity.
    localparam int unsigned FRAME_BITS_NOPAR = 32'd10;
    localparam int unsigned FRAME_BITS_PAR   = 32'd11;

    // Index of the final data bit in the bit counter.
    localparam logic [2:0] LAST_DATA_BIT = 3'd7;

    // Even parity bit: makes the total count of ones across data + parity even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Baud-rate divider: counts CLKS_PER_BIT rclk cycles per serial bit and
// flags the final cycle of each bit. Cleared whenever a new frame is loaded
// so the start bit always gets a full bit period.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 32'd16
) (
    input  logic rclk,
    input  logic rrst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 32'd1);

    logic [CW-1:0] cnt_r;

    // Bit-period counter: 0..CLKS_PER_BIT-1, wrapping at the bit boundary.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (cnt_r == LAST_CNT) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1'b1);
        end
    end

    assign tick = (cnt_r == LAST_CNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side UART transmitter. Pops bytes from a first-word-fall-through
// FIFO and shifts them out LSB-first with optional even parity and one stop
// bit. When the FIFO still holds data at the end of a stop bit, the next byte
// is popped in that same cycle so frames run back-to-back with no idle gap.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 32'd16,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic       rclk,
    input  logic       rrst,
    input  logic       rempty,
    input  logic [7:0] rd_data,
    output logic       rinc,
    output logic       tx,
    output logic       busy
);

    uart_state_e state_r;
    uart_state_e state_next_s;
    logic [7:0]  shift_r;
    logic        parity_r;
    logic [2:0]  bit_cnt_r;
    logic        tx_r;
    logic        tx_next_s;
    logic        tick_s;
    logic        rinc_s;

    // A pop restarts the bit timer so the start bit lasts a full period.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .rclk  (rclk),
        .rrst  (rrst),
        .clear (rinc_s),
        .tick  (tick_s)
    );

    // State register; reset overrides every transition.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: each non-idle state advances on the bit boundary.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!rempty) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    state_next_s = DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (tick_s && (bit_cnt_r == LAST_DATA_BIT)) begin
                    state_next_s = PARITY_EN ? PARITY : STOP;
                end else begin
                    state_next_s = DATA;
                end
            end
            PARITY: begin
                if (tick_s) begin
                    state_next_s = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
            STOP: begin
                if (tick_s) begin
                    state_next_s = rempty ? IDLE : START;
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Output logic: pop strobe, and the line level for the coming cycle so tx
    // can be driven straight from a flop.
    always_comb begin
        rinc_s = 1'b0;
        if (rrst) begin
            rinc_s = 1'b0;
        end else if (rempty) begin
            rinc_s = 1'b0;
        end else if (state_r == IDLE) begin
            rinc_s = 1'b1;
        end else if ((state_r == STOP) && tick_s) begin
            rinc_s = 1'b1;
        end else begin
            rinc_s = 1'b0;
        end

        tx_next_s = tx_r;
        if (rinc_s) begin
            tx_next_s = 1'b0;
        end else if (state_next_s == IDLE) begin
            tx_next_s = 1'b1;
        end else if (tick_s) begin
            case (state_r)
                START:   tx_next_s = shift_r[0];
                DATA: begin
                    if (bit_cnt_r == LAST_DATA_BIT) begin
                        tx_next_s = PARITY_EN ? parity_r : 1'b1;
                    end else begin
                        tx_next_s = shift_r[1];
                    end
                end
                PARITY:  tx_next_s = 1'b1;
                STOP:    tx_next_s = 1'b1;
                default: tx_next_s = 1'b1;
            endcase
        end else begin
            tx_next_s = tx_r;
        end
    end

    // Datapath: load on pop, shift at each data-bit boundary, register tx.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            shift_r   <= 8'h00;
            parity_r  <= 1'b0;
            bit_cnt_r <= 3'd0;
            tx_r      <= 1'b1;
        end else begin
            tx_r <= tx_next_s;
            if (rinc_s) begin
                shift_r   <= rd_data;
                parity_r  <= even_parity(rd_data);
                bit_cnt_r <= 3'd0;
            end else if ((state_r == DATA) && tick_s) begin
                shift_r   <= {1'b0, shift_r[7:1]};
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
        end
    end

    assign rinc = rinc_s;
    assign tx   = tx_r;
    assign busy = (state_r != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (no parity / even parity) fed from
// behavioural FIFO models. Pushing a byte queues its expected frame; a
// negedge monitor decodes every frame on tx and compares against the queue.
module tb_fifo_uart_tx;
    import fifo_uart_pkg::*;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rrst = 1'b1;
    logic [1:0] rempty_v = 2'b11;
    logic [7:0] rd_data_v [2];
    logic [1:0] rinc_w;
    logic [1:0] tx_w;
    logic [1:0] busy_w;

    logic [7:0] fifo_q [2][$];
    logic [7:0] exp_q  [2][$];
    int         exp_rd [2] = '{0, 0};

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic        in_frame    [2] = '{1'b0, 1'b0};
    int          pos         [2] = '{0, 0};
    logic        hold_err    [2] = '{1'b0, 1'b0};
    logic [10:0] fbits       [2];
    int          last_start  [2] = '{0, 0};
    int          prev_start  [2] = '{0, 0};
    int          starts      [2] = '{0, 0};
    int          frames_done [2] = '{0, 0};
    int          last_rinc   [2] = '{-100, -100};
    int          rinc_cnt    [2] = '{0, 0};
    int          rinc_gap    [2] = '{0, 0};
    logic        last_par    [2] = '{1'b0, 1'b0};
    int          mon_nb;
    int          mon_bit;
    logic [7:0]  mon_exp;

    logic [1:0] smp_tx;
    logic [1:0] smp_busy;
    logic [1:0] smp_rinc;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
        .rclk(clk), .rrst(rrst), .rempty(rempty_v[0]), .rd_data(rd_data_v[0]),
        .rinc(rinc_w[0]), .tx(tx_w[0]), .busy(busy_w[0])
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
        .rclk(clk), .rrst(rrst), .rempty(rempty_v[1]), .rd_data(rd_data_v[1]),
        .rinc(rinc_w[1]), .tx(tx_w[1]), .busy(busy_w[1])
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference frame, bit 0 transmitted first: start, data LSB-first, parity/stop, stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] b, input bit par);
        logic [10:0] f;
        f = {2'b11, b, 1'b0};
        if (par) f[9] = ^b;
        return f;
    endfunction

    task automatic refresh(input int g);
        rempty_v[g] = (fifo_q[g].size() == 0);
        rd_data_v[g] = (fifo_q[g].size() == 0) ? 8'h00 : fifo_q[g][0];
    endtask

    task automatic push(input int g, input logic [7:0] b);
        fifo_q[g].push_back(b);
        exp_q[g].push_back(b);
        refresh(g);
    endtask

    // One clock: sample outputs at negedge, then apply the FIFO pop after posedge.
    task automatic tick();
        @(negedge clk);
        smp_tx = tx_w;
        smp_busy = busy_w;
        smp_rinc = rinc_w;
        @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            if (smp_rinc[g] && (fifo_q[g].size() > 0)) begin
                void'(fifo_q[g].pop_front());
                refresh(g);
            end
        end
    endtask

    // Bounded wait: kind 0 = frames completed, 1 = start bits seen, 2 = rinc pulses.
    task automatic wait_for(input int kind, input int g, input int n, input string what);
        int cur;
        for (int i = 0; i < 400; i++) begin
            cur = (kind == 0) ? frames_done[g] : ((kind == 1) ? starts[g] : rinc_cnt[g]);
            if (cur >= n) return;
            tick();
        end
        chk({"timeout_", what}, 0, 1);
    endtask

    // Monitor: decodes frames on tx, checks bit hold, busy, latency and rinc rules.
    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int g = 0; g < 2; g++) begin
            mon_nb = (g == 1) ? FRAME_BITS_PAR : FRAME_BITS_NOPAR;
            if (rrst) begin
                chk("rinc_in_reset", int'(rinc_w[g]), 0);
                if (in_frame[g]) begin
                    in_frame[g] = 1'b0;
                    exp_rd[g] = exp_rd[g] + 1;
                end
            end else begin
                if (!in_frame[g] && (tx_w[g] == 1'b0)) begin
                    in_frame[g] = 1'b1;
                    pos[g] = 0;
                    hold_err[g] = 1'b0;
                    fbits[g] = 11'h7FF;
                    prev_start[g] = last_start[g];
                    last_start[g] = cyc;
                    starts[g] = starts[g] + 1;
                    chk("start_latency", cyc - last_rinc[g], 1);
                end
                if (in_frame[g]) begin
                    mon_bit = pos[g] / CPB;
                    if ((pos[g] % CPB) == 0) begin
                        fbits[g][mon_bit] = tx_w[g];
                    end else if (tx_w[g] != fbits[g][mon_bit]) begin
                        hold_err[g] = 1'b1;
                    end
                    if (!busy_w[g]) hold_err[g] = 1'b1;
                    pos[g] = pos[g] + 1;
                    if (pos[g] == mon_nb * CPB) begin
                        in_frame[g] = 1'b0;
                        chk("frame_hold_busy", int'(hold_err[g]), 0);
                        if (exp_rd[g] < exp_q[g].size()) begin
                            mon_exp = exp_q[g][exp_rd[g]];
                            exp_rd[g] = exp_rd[g] + 1;
                            chk("frame_bits", int'(fbits[g]), int'(exp_frame(mon_exp, g == 1)));
                        end else begin
                            chk("frame_unexpected", 1, 0);
                        end
                        last_par[g] = fbits[g][9];
                        frames_done[g] = frames_done[g] + 1;
                    end
                end
                if (rinc_w[g]) begin
                    chk("rinc_while_empty", int'(rempty_v[g]), 0);
                    if (rinc_cnt[g] > 0) rinc_gap[g] = cyc - last_rinc[g];
                    last_rinc[g] = cyc;
                    rinc_cnt[g] = rinc_cnt[g] + 1;
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        int bad;
        int s;
        int rc;
        int st;
        refresh(0);
        refresh(1);

        // Reset state.
        rrst = 1'b1;
        tick();
        tick();
        chk("reset_tx", int'(smp_tx), 3);
        chk("reset_busy", int'(smp_busy), 0);
        chk("reset_rinc", int'(smp_rinc), 0);
        rrst = 1'b0;

        // Empty FIFO held for 100 cycles.
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if ((smp_tx != 2'b11) || (smp_busy != 2'b00) || (smp_rinc != 2'b00)) bad = bad + 1;
        end
        chk("idle_hold", bad, 0);

        // Single byte 0xA5: tx 0,1,0,1,0,0,1,0,1,1.
        push(0, 8'hA5);
        wait_for(0, 0, 1, "a5");
        tick();
        chk("a5_after_tx", int'(smp_tx[0]), 1);
        chk("a5_after_busy", int'(smp_busy[0]), 0);
        chk("a5_rinc_count", rinc_cnt[0], 1);

        // Back-to-back 0x00, 0xFF.
        push(0, 8'h00);
        push(0, 8'hFF);
        wait_for(0, 0, 3, "b2b");
        chk("b2b_start_gap", last_start[0] - prev_start[0], 40);
        chk("b2b_rinc_gap", rinc_gap[0], 40);
        chk("b2b_rinc_count", rinc_cnt[0], 3);

        // Parity instance: 0x07 -> parity 1, 0x03 -> parity 0, 44-cycle frames.
        push(1, 8'h07);
        push(1, 8'h03);
        wait_for(0, 1, 1, "par07");
        chk("par_07", int'(last_par[1]), 1);
        wait_for(0, 1, 2, "par03");
        chk("par_03", int'(last_par[1]), 0);
        chk("par_frame_len", last_start[1] - prev_start[1], 44);

        // Late data: next byte arrives while 0x81 is in DATA.
        st = starts[0];
        push(0, 8'h81);
        wait_for(1, 0, st + 1, "late_start");
        repeat (10) tick();
        s = last_start[0];
        rc = rinc_cnt[0];
        push(0, 8'h42);
        wait_for(2, 0, rc + 1, "late_rinc");
        chk("late_rinc_pos", last_rinc[0] - s, 39);
        wait_for(0, 0, 5, "late_frames");
        chk("late_next_start", last_start[0] - s, 40);
        chk("late_rinc_count", rinc_cnt[0], 5);

        // Mid-frame reset during data bit 3 of 0x5A, then 0x3C.
        st = starts[0];
        push(0, 8'h5A);
        wait_for(1, 0, st + 1, "rst_start");
        repeat (16) tick();
        rrst = 1'b1;
        tick();
        rrst = 1'b0;
        tick();
        chk("midrst_tx", int'(smp_tx[0]), 1);
        chk("midrst_busy", int'(smp_busy[0]), 0);
        chk("midrst_rinc", int'(smp_rinc[0]), 0);
        push(0, 8'h3C);
        wait_for(0, 0, 6, "after_rst");
        repeat (5) tick();

        chk("exp_consumed_0", exp_rd[0], exp_q[0].size());
        chk("exp_consumed_1", exp_rd[1], exp_q[1].size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
